// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: occupancy encoding
// and default bundle widths for the standard stage boundaries.
package pipe_stage_reg_pkg;

  localparam int DATA_W_DEF = 96;  // {ALU_OUT, MEM_OUT, PC}
  localparam int CTRL_W_DEF = 8;   // {RES, MEM_TO_REG, REG_WRITE_ENABLED, WRITE_ADDR}
  localparam int CNT_W_DEF  = 16;

  // Every control bit idle: no register write, no memory op.
  localparam logic CTRL_BUBBLE_BIT = 1'b0;

  // Occupancy encoded as {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } stage_st_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One held bundle (data + control) with a valid flag. Clear drops the entry and
// parks control at the bubble value; data only changes on load.
module pipe_stage_reg_slot #(
  parameter int                DATA_W      = 96,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= CTRL_BUBBLE;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, stall, flush-to-bubble and an
// optional skid entry that makes in_ready a pure register output.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{CTRL_BUBBLE_BIT}},
  parameter bit                SKID        = 1'b0,
  parameter int                CNT_W       = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [CNT_W-1:0]  o_bp_cycles
);

  logic              w_m_valid, w_m_load, w_m_clear, w_accept, w_pop;
  logic [DATA_W-1:0] w_m_din;
  logic [CTRL_W-1:0] w_m_cin;
  logic [CNT_W-1:0]  r_bp;

  assign w_pop = w_m_valid & i_out_ready;

  pipe_stage_reg_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)
  ) u_main (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(w_m_load), .i_clear(w_m_clear),
    .i_data(w_m_din), .i_ctrl(w_m_cin),
    .o_valid(w_m_valid), .o_data(o_out_data), .o_ctrl(o_out_ctrl)
  );

  if (SKID) begin : g_skid
    logic              r_in_ready;
    logic              w_s_valid, w_s_load, w_s_clear, w_s_next, w_m_from_s;
    logic [DATA_W-1:0] w_s_data;
    logic [CTRL_W-1:0] w_s_ctrl;
    stage_st_e         w_state;

    // in_ready is registered and blind to stall, so stall gates the transfer here.
    assign w_accept = i_in_valid & r_in_ready & ~i_stall;

    always_comb begin
      w_state    = stage_st_e'({w_m_valid, w_s_valid});
      w_m_load   = 1'b0;
      w_m_clear  = 1'b0;
      w_s_load   = 1'b0;
      w_s_clear  = 1'b0;
      w_s_next   = 1'b0;
      w_m_from_s = 1'b0;
      case (w_state)
        ST_EMPTY: w_m_load = w_accept;
        ST_ONE: begin
          if (w_pop) begin
            w_m_load  = w_accept;
            w_m_clear = ~w_accept;
          end else begin
            w_s_load = w_accept;
            w_s_next = w_accept;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_m_load   = 1'b1;
            w_m_from_s = 1'b1;
            w_s_clear  = 1'b1;
          end else begin
            w_s_next = 1'b1;
          end
        end
        default: begin
          w_m_clear = 1'b1;
          w_s_clear = 1'b1;
        end
      endcase
      // Flush beats everything, including an accept completing this cycle.
      if (i_flush) begin
        w_m_load  = 1'b0;
        w_s_load  = 1'b0;
        w_m_clear = 1'b1;
        w_s_clear = 1'b1;
        w_s_next  = 1'b0;
      end
    end

    assign w_m_din = w_m_from_s ? w_s_data : i_in_data;
    assign w_m_cin = w_m_from_s ? w_s_ctrl : i_in_ctrl;

    pipe_stage_reg_slot #(
      .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)
    ) u_skid (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(w_s_load), .i_clear(w_s_clear),
      .i_data(i_in_data), .i_ctrl(i_in_ctrl),
      .o_valid(w_s_valid), .o_data(w_s_data), .o_ctrl(w_s_ctrl)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_in_ready <= 1'b0;
      else          r_in_ready <= ~w_s_next;
    end

    assign o_in_ready = r_in_ready;
  end else begin : g_single
    logic w_in_ready;

    assign w_in_ready = ~i_stall & (~w_m_valid | i_out_ready);
    assign w_accept   = i_in_valid & w_in_ready;
    assign w_m_load   = w_accept & ~i_flush;
    assign w_m_clear  = i_flush | (w_pop & ~w_accept);
    assign w_m_din    = i_in_data;
    assign w_m_cin    = i_in_ctrl;
    assign o_in_ready = w_in_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                r_bp <= '0;
    else if (w_m_valid & ~i_out_ready & ~&r_bp)  r_bp <= r_bp + CNT_W'(1);
  end

  assign o_out_valid = w_m_valid;
  assign o_bp_cycles = r_bp;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: dut0 is the single-register build with a 4-bit counter,
// dut1 the skid build. A queue per DUT holds what the stage should contain.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam logic [CW-1:0] BUB = 8'h5A;

  typedef struct packed { logic [DW-1:0] d; logic [CW-1:0] c; } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic st0, fl0, iv0, or0, ir0, ov0;
  logic st1, fl1, iv1, or1, ir1, ov1;
  logic [DW-1:0] d0, od0, d1, od1;
  logic [CW-1:0] c0, oc0, c1, oc1;
  logic [3:0]    bp0;
  logic [15:0]   bp1;

  ent_t        q0[$], q1[$];
  logic [3:0]  eb0;
  logic [15:0] eb1;
  logic        er1;
  bit          acc1_last;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .SKID(1'b0), .CNT_W(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(st0), .i_flush(fl0), .i_in_valid(iv0),
    .o_in_ready(ir0), .i_in_data(d0), .i_in_ctrl(c0), .o_out_valid(ov0),
    .i_out_ready(or0), .o_out_data(od0), .o_out_ctrl(oc0), .o_bp_cycles(bp0));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .SKID(1'b1), .CNT_W(16)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(st1), .i_flush(fl1), .i_in_valid(iv1),
    .o_in_ready(ir1), .i_in_data(d1), .i_in_ctrl(c1), .o_out_valid(ov1),
    .i_out_ready(or1), .o_out_data(od1), .o_out_ctrl(oc1), .o_bp_cycles(bp1));

  // Advance one clock, updating the expected contents from the inputs now applied.
  task automatic tick();
    ent_t e;
    bit acc0, acc1, pop0, pop1;
    acc1_last = 1'b0;
    if (rst_n) begin
      acc0 = iv0 && !st0 && (q0.size() == 0 || or0);
      pop0 = q0.size() != 0 && or0;
      if (q0.size() != 0 && !or0 && eb0 != 4'hF) eb0++;
      if (fl0) q0.delete();
      else begin
        if (pop0) void'(q0.pop_front());
        if (acc0) begin e.d = d0; e.c = c0; q0.push_back(e); end
      end
      acc1 = iv1 && !st1 && er1;
      pop1 = q1.size() != 0 && or1;
      if (q1.size() != 0 && !or1 && eb1 != 16'hFFFF) eb1++;
      if (fl1) q1.delete();
      else begin
        if (pop1) void'(q1.pop_front());
        if (acc1) begin e.d = d1; e.c = c1; q1.push_back(e); end
      end
      acc1_last = acc1;
    end
    @(posedge clk);
    #1;
    er1 = rst_n ? (q1.size() < 2) : 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    st0 = 0; fl0 = 0; iv0 = 0; or0 = 1; d0 = '0; c0 = '0;
    st1 = 0; fl1 = 0; iv1 = 0; or1 = 1; d1 = '0; c1 = '0;
    eb0 = '0; eb1 = '0; er1 = 1'b0;
    repeat (2) tick();
    n_chk++; if (ov0 !== 1'b0) $display("FAIL rst_ov0 got %b exp 0", ov0); else n_pass++;
    n_chk++; if (oc0 !== BUB) $display("FAIL rst_oc0 got %h exp %h", oc0, BUB); else n_pass++;
    n_chk++; if (od0 !== '0) $display("FAIL rst_od0 got %h exp 0", od0); else n_pass++;
    n_chk++; if (oc1 !== BUB) $display("FAIL rst_oc1 got %h exp %h", oc1, BUB); else n_pass++;
    n_chk++; if (ir1 !== 1'b0) $display("FAIL rst_ir1 got %b exp 0", ir1); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++; if (ir1 !== er1) $display("FAIL rel_ir1 got %b exp %b", ir1, er1); else n_pass++;
    // Mid-stream: park one entry in each stage, then pulse reset between edges.
    iv0 = 1; d0 = 16'hAAAA; c0 = 8'h11; or0 = 0;
    iv1 = 1; d1 = 16'hBBBB; c1 = 8'h22; or1 = 0;
    tick();
    iv0 = 0; iv1 = 0;
    n_chk++; if (ov0 !== 1'b1) $display("FAIL mid_ov0 got %b exp 1", ov0); else n_pass++;
    n_chk++; if (ov1 !== 1'b1) $display("FAIL mid_ov1 got %b exp 1", ov1); else n_pass++;
    #2 rst_n = 1'b0;
    q0.delete(); q1.delete(); eb0 = '0; eb1 = '0; er1 = 1'b0;
    #1;
    n_chk++; if (ov0 !== 1'b0 || oc0 !== BUB) $display("FAIL async_rst0 got v=%b c=%h exp v=0 c=%h", ov0, oc0, BUB); else n_pass++;
    n_chk++; if (ov1 !== 1'b0 || oc1 !== BUB) $display("FAIL async_rst1 got v=%b c=%h exp v=0 c=%h", ov1, oc1, BUB); else n_pass++;
    n_chk++; if (od1 !== '0 || bp1 !== '0) $display("FAIL async_rst1_d got d=%h bp=%0d exp 0", od1, bp1); else n_pass++;
    n_chk++; if (ir1 !== 1'b0) $display("FAIL async_ir1 got %b exp 0", ir1); else n_pass++;
    #1 rst_n = 1'b1;
    or0 = 1; or1 = 1;
    tick();
    n_chk++; if (ir1 !== er1) $display("FAIL rel2_ir1 got %b exp %b", ir1, er1); else n_pass++;
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      iv0 = 1; d0 = DW'(i); c0 = CW'(8'h10 + i);
      #1;
      n_chk++; if (ir0 !== (!st0 && (q0.size() == 0 || or0))) $display("FAIL stream_ir0 beat %0d got %b", i, ir0); else n_pass++;
      tick();
      n_chk++; if (ov0 !== 1'b1 || od0 !== DW'(i)) $display("FAIL stream_out beat %0d got v=%b d=%h exp v=1 d=%h", i, ov0, od0, DW'(i)); else n_pass++;
      n_chk++; if (q0.size() == 0 || oc0 !== q0[0].c) $display("FAIL stream_ctrl beat %0d got %h", i, oc0); else n_pass++;
    end
    iv0 = 0;
    tick();
    n_chk++; if (ov0 !== 1'b0 || oc0 !== BUB) $display("FAIL stream_drain got v=%b c=%h exp v=0 c=%h", ov0, oc0, BUB); else n_pass++;
  endtask

  task automatic test_skid_bp();
    logic [DW-1:0] got[3];
    logic [DW-1:0] exp_d[3];
    int n = 0;
    exp_d[0] = 16'hA001; exp_d[1] = 16'hB002; exp_d[2] = 16'hC003;
    iv1 = 1; d1 = exp_d[0]; c1 = 8'h31;
    tick();
    or1 = 0; d1 = exp_d[1]; c1 = 8'h32;
    n_chk++; if (ir1 !== er1) $display("FAIL skid_ir_b got %b exp %b", ir1, er1); else n_pass++;
    tick();
    d1 = exp_d[2]; c1 = 8'h33;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (ir1 !== 1'b0) $display("FAIL skid_full_ir cyc %0d got %b exp 0", k, ir1); else n_pass++;
      n_chk++; if (ov1 !== 1'b1 || od1 !== exp_d[0]) $display("FAIL skid_head cyc %0d got v=%b d=%h exp v=1 d=%h", k, ov1, od1, exp_d[0]); else n_pass++;
      tick();
    end
    n_chk++; if (bp1 !== 16'd4 || bp1 !== eb1) $display("FAIL skid_bp got %0d exp 4 (model %0d)", bp1, eb1); else n_pass++;
    or1 = 1;
    for (int k = 0; k < 10 && !(n == 3 && q1.size() == 0); k++) begin
      if (q1.size() != 0) begin
        n_chk++; if (ov1 !== 1'b1 || od1 !== q1[0].d || oc1 !== q1[0].c) $display("FAIL skid_pop got v=%b d=%h c=%h exp d=%h c=%h", ov1, od1, oc1, q1[0].d, q1[0].c); else n_pass++;
        if (n < 3) got[n] = od1;
        n++;
      end
      tick();
      if (acc1_last) iv1 = 0;
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got[k] !== exp_d[k]) $display("FAIL skid_order idx %0d got %h exp %h", k, got[k], exp_d[k]); else n_pass++;
    end
    n_chk++; if (ov1 !== 1'b0 || bp1 !== 16'd4) $display("FAIL skid_end got v=%b bp=%0d exp v=0 bp=4", ov1, bp1); else n_pass++;
  endtask

  task automatic test_flush();
    // skid build: two held, flush; then one held, flush racing an accept
    or1 = 0; iv1 = 1; d1 = 16'h0A0A; c1 = 8'h41; tick();
    d1 = 16'h0B0B; c1 = 8'h42; tick();
    fl1 = 1; d1 = 16'h0D0D; c1 = 8'h44; tick();
    fl1 = 0; iv1 = 0;
    n_chk++; if (ov1 !== 1'b0 || oc1 !== BUB) $display("FAIL flush2_out got v=%b c=%h exp v=0 c=%h", ov1, oc1, BUB); else n_pass++;
    n_chk++; if (od1 !== 16'h0A0A || ir1 !== er1) $display("FAIL flush2_hold got d=%h rdy=%b exp d=0a0a rdy=%b", od1, ir1, er1); else n_pass++;
    iv1 = 1; d1 = 16'h0E0E; c1 = 8'h45; tick();
    fl1 = 1; d1 = 16'h0F0F; c1 = 8'h46;
    n_chk++; if (ir1 !== er1) $display("FAIL flush1_ir got %b exp %b", ir1, er1); else n_pass++;
    tick();
    fl1 = 0; iv1 = 0; or1 = 1;
    n_chk++; if (ov1 !== 1'b0 || oc1 !== BUB || od1 !== 16'h0E0E) $display("FAIL flush1_out got v=%b c=%h d=%h exp v=0 c=%h d=0e0e", ov1, oc1, od1, BUB); else n_pass++;
    repeat (2) begin
      tick();
      n_chk++; if (ov1 !== 1'b0) $display("FAIL flush1_leak got v=%b d=%h exp v=0", ov1, od1); else n_pass++;
    end
    // single build: flush with accept, then flush with stall
    or0 = 0; iv0 = 1; d0 = 16'h1111; c0 = 8'h51; tick();
    or0 = 1; fl0 = 1; d0 = 16'h2222; c0 = 8'h52; tick();
    fl0 = 0; iv0 = 0;
    n_chk++; if (ov0 !== 1'b0 || oc0 !== BUB || od0 !== 16'h1111) $display("FAIL flush0_out got v=%b c=%h d=%h exp v=0 c=%h d=1111", ov0, oc0, od0, BUB); else n_pass++;
    or0 = 0; iv0 = 1; d0 = 16'h3333; c0 = 8'h53; tick();
    fl0 = 1; st0 = 1; d0 = 16'h4444; c0 = 8'h54;
    #1;
    n_chk++; if (ir0 !== 1'b0) $display("FAIL flush_stall_ir got %b exp 0", ir0); else n_pass++;
    tick();
    fl0 = 0; st0 = 0; iv0 = 0; or0 = 1;
    n_chk++; if (ov0 !== 1'b0 || oc0 !== BUB) $display("FAIL flush_stall_out got v=%b c=%h exp v=0 c=%h", ov0, oc0, BUB); else n_pass++;
    tick();
    n_chk++; if (ov0 !== 1'b0) $display("FAIL flush_stall_leak got v=%b exp 0", ov0); else n_pass++;
  endtask

  task automatic test_stall();
    or0 = 0; iv0 = 1; d0 = 16'h5150; c0 = 8'h61;
    or1 = 0; iv1 = 1; d1 = 16'h5151; c1 = 8'h62;
    tick();
    st0 = 1; or0 = 1; d0 = 16'h6160; c0 = 8'h63;
    st1 = 1; or1 = 1; d1 = 16'h6161; c1 = 8'h64;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (ir0 !== 1'b0) $display("FAIL stall_ir0 cyc %0d got %b exp 0", k, ir0); else n_pass++;
      tick();
      n_chk++; if (ov0 !== (q0.size() != 0) || ov1 !== (q1.size() != 0)) $display("FAIL stall_vld cyc %0d got %b/%b exp %b/%b", k, ov0, ov1, q0.size() != 0, q1.size() != 0); else n_pass++;
    end
    st0 = 0; st1 = 0;
    #1;
    n_chk++; if (ir0 !== 1'b1) $display("FAIL unstall_ir0 got %b exp 1", ir0); else n_pass++;
    tick();
    iv0 = 0; iv1 = 0;
    n_chk++; if (ov0 !== 1'b1 || od0 !== 16'h6160) $display("FAIL unstall_out0 got v=%b d=%h exp v=1 d=6160", ov0, od0); else n_pass++;
    n_chk++; if (ov1 !== 1'b1 || od1 !== 16'h6161) $display("FAIL unstall_out1 got v=%b d=%h exp v=1 d=6161", ov1, od1); else n_pass++;
    tick();
  endtask

  task automatic test_sat();
    or0 = 0; iv0 = 1; d0 = 16'h7777; c0 = 8'h71;
    tick();
    iv0 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_chk++; if (bp0 !== eb0) $display("FAIL sat_cnt cyc %0d got %0d exp %0d", k, bp0, eb0); else n_pass++;
    end
    n_chk++; if (bp0 !== 4'hF) $display("FAIL sat_top got %0d exp 15", bp0); else n_pass++;
    or0 = 1;
    tick();
    n_chk++; if (bp0 !== 4'hF || ov0 !== 1'b0) $display("FAIL sat_hold got bp=%0d v=%b exp bp=15 v=0", bp0, ov0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_bp();
    test_flush();
    test_stall();
    test_sat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no end exp finish");
    $fatal(1);
  end

endmodule
